pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Stall/flush controller for the 5-stage pipeline. It drives the IF/ID and ID/EX
//  pipeline registers from decode-stage Tuse and EX/MEM-stage Tnew information.
//  It owns the multi-cycle mult/div busy FSM and keeps a saturating stall-cycle counter.
//  Sits beside the ID stage. Its outputs gate the PC, hold IF/ID and bubble ID/EX via that register's clr.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles after a mult/multu start (>=1)
//  DIV_CYCLES   10  busy cycles after a div/divu start (>=1)
//  CNT_W        16  width of stall_cnt
// PORTS
//  clk          in   1      pipeline clock, all state on posedge
//  reset        in   1      synchronous, active-low reset
//  rs_id        in   5      rs field of instr in ID
//  rt_id        in   5      rt field of instr in ID
//  tuse_rs_id   in   2      cycles until ID instr needs rs (3 = never)
//  tuse_rt_id   in   2      cycles until ID instr needs rt (3 = never)
//  md_use_id    in   1      ID instr is mult/div/mfhi/mflo/mthi/mtlo
//  wa_ex        in   5      dest reg of instr in EX (0 = none)
//  tnew_ex      in   2      cycles until EX instr result is forwardable
//  wa_mem       in   5      dest reg of instr in MEM (0 = none)
//  tnew_mem     in   2      cycles until MEM instr result is forwardable
//  md_start_ex  in   1      mult/div instr in EX this cycle (start pulse)
//  md_is_div_ex in   1      qualifies md_start_ex: 1 = div, 0 = mult
//  pc_en        out  1      PC write enable
//  if_id_en     out  1      IF/ID register enable
//  id_ex_clr    out  1      ID/EX clr (insert bubble)
//  md_busy      out  1      mult/div unit busy
//  md_done      out  1      last busy cycle of mult/div
//  md_err       out  1      sticky: start seen while busy
//  stall_cnt    out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  Data stall (combinational):
//   stall_rs = rs_id!=0 & ((rs_id==wa_ex & tnew_ex>tuse_rs_id) | (rs_id==wa_mem & tnew_mem>tuse_rs_id))
//   stall_rt is the same expression using rt_id and tuse_rt_id.
//   Register 0 never stalls; a matching EX write takes precedence only in forwarding, not here.
//  MD stall: md_use_id & (md_busy | md_start_ex).
//  stall = stall_rs | stall_rt | md stall.
//   pc_en = ~stall, if_id_en = ~stall, id_ex_clr = stall. No latency; no registered path.
//   These three outputs are combinational and remain valid during reset.
//   The ID/EX register applies its own reset.
//  MD FSM states: IDLE, BUSY. Down-counter md_cnt is wide enough for the larger parameter.
//   IDLE & md_start_ex: go to BUSY and load md_cnt = md_is_div_ex ? DIV_CYCLES : MULT_CYCLES.
//   BUSY: md_cnt decrements every cycle. When md_cnt==1, next state is IDLE.
//   md_busy = (state==BUSY).
//   md_done = (state==BUSY & md_cnt==1). It pulses for exactly one cycle per operation.
//   The start cycle itself is not busy, but the md stall still covers it via md_start_ex.
//   A dependent md instr therefore stalls for N+1 cycles.
//   md_start_ex while BUSY: ignored, with no reload and the count unchanged. md_err is set and
//   held until reset. Because ID stalls, this case indicates a pipeline bug.
//  stall_cnt: +1 on every cycle with stall=1 and reset high. It saturates at all-ones and does not wrap.
//  Reset (reset==0 at posedge): state=IDLE, md_cnt=0, md_busy=0, md_done=0, md_err=0, stall_cnt=0.
//   Reset wins over a simultaneous md_start_ex. Mid-operation reset aborts the op with no md_done.
// TESTING
//  1. wa_ex=1, tnew_ex=2; ID rs_id=1, tuse_rs_id=1 -> pc_en=0, if_id_en=0, id_ex_clr=1.
//     Next cycle wa_mem=1, tnew_mem=1 -> no stall.
//  2. rs_id=0, wa_ex=0, tnew_ex=2, tuse_rs_id=0 -> no stall. rt_id=5 with tuse_rt_id=3 vs wa_ex=5 -> no stall.
//  3. md_start_ex=1, md_is_div_ex=1; mflo held in ID -> md_busy=1 for 10 cycles, md_done on the 10th.
//     Stall lasts 11 cycles and stall_cnt=11.
//  4. Mult start, then reset=0 on busy cycle 3 -> next cycle md_busy=0, stall_cnt=0, no md_done pulse.
//  5. With CNT_W=4, force stall for 20 cycles -> stall_cnt stops at 15.
//  6. md_start_ex again during BUSY (cycle 2 of div) -> md_err=1 stays set.
//     md_done still fires 10 cycles after the first start.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Compares decode-stage operand need times (Tuse) against the result-ready times (Tnew)
// of the instructions in EX and MEM, and tracks the multi-cycle mult/div unit.
// The PC/IF/ID hold and ID/EX bubble are purely combinational so they act in the same cycle.
module pipe_hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs_id,
   input  logic [4:0]       rt_id,
   input  logic [1:0]       tuse_rs_id,
   input  logic [1:0]       tuse_rt_id,
   input  logic             md_use_id,
   input  logic [4:0]       wa_ex,
   input  logic [1:0]       tnew_ex,
   input  logic [4:0]       wa_mem,
   input  logic [1:0]       tnew_mem,
   input  logic             md_start_ex,
   input  logic             md_is_div_ex,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_clr,
   output logic             md_busy,
   output logic             md_done,
   output logic             md_err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int MD_W    = $clog2(MAX_CYC + 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

   md_state_t       state;
   md_state_t       state_next;
   logic [MD_W-1:0] md_cnt;
   logic [MD_W-1:0] md_cnt_next;

   logic stall_rs;
   logic stall_rt;
   logic stall_md;
   logic stall;

   // Data hazards: a source register stalls when a producer in EX or MEM will not have its
   // result ready before this instruction needs it; register 0 is never a real dependency.
   always_comb begin
      stall_rs = 1'b0;
      stall_rt = 1'b0;
      if (rs_id != 5'd0) begin
         stall_rs = ((rs_id == wa_ex)  && (tnew_ex  > tuse_rs_id)) ||
                    ((rs_id == wa_mem) && (tnew_mem > tuse_rs_id));
      end
      if (rt_id != 5'd0) begin
         stall_rt = ((rt_id == wa_ex)  && (tnew_ex  > tuse_rt_id)) ||
                    ((rt_id == wa_mem) && (tnew_mem > tuse_rt_id));
      end
   end

   // A mult/div-unit user in ID waits while the unit runs, including the cycle the op starts.
   always_comb begin
      stall_md  = md_use_id && (md_busy || md_start_ex);
      stall     = stall_rs || stall_rt || stall_md;
      pc_en     = !stall;
      if_id_en  = !stall;
      id_ex_clr = stall;
   end

   // Mult/div sequencer next state: a start in IDLE loads the op length, BUSY counts down to 1.
   // A start seen while BUSY is ignored entirely (only flagged through md_err).
   always_comb begin
      state_next  = state;
      md_cnt_next = md_cnt;
      case (state)
         IDLE: begin
            if (md_start_ex) begin
               state_next  = BUSY;
               md_cnt_next = md_is_div_ex ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
            end
         end
         BUSY: begin
            md_cnt_next = md_cnt - MD_W'(1);
            if (md_cnt == MD_W'(1)) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next  = IDLE;
            md_cnt_next = '0;
         end
      endcase
   end

   // Sequencer state register; reset aborts any op in flight without a done pulse.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         md_cnt <= '0;
      end else begin
         state  <= state_next;
         md_cnt <= md_cnt_next;
      end
   end

   // Busy/done are decoded straight from the sequencer so done marks the final busy cycle.
   always_comb begin
      md_busy = (state == BUSY);
      md_done = (state == BUSY) && (md_cnt == MD_W'(1));
   end

   // Sticky error: a new start while the unit is busy means ID failed to hold a dependent op.
   always_ff @(posedge clk) begin
      if (!reset) begin
         md_err <= 1'b0;
      end else if ((state == BUSY) && md_start_ex) begin
         md_err <= 1'b1;
      end
   end

   // Stall-cycle statistics counter, saturating at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
